dt_pack: RTL

- Reader/packer on the result side of the distance-transform datapath: scans the 128x128 byte-per-pixel result RAM and thresholds each pixel to one bit.
- Packs the bits MSB-first into 16-bit words, in the same format as the input-image ROM: 1024 words, bit 15 = leftmost pixel.
- Writes the packed words to a 1024x16 output RAM.
- Used to regenerate or check binary masks from DT results and to feed the packed image to the next stage.

---
 rtl/dt_pkg.sv | 18 +
 rtl/dt_pack_shreg.sv | 32 +++
 rtl/dt_pack.sv | 105 ++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// Shared constants and state type for the distance-transform result packer.
// Build option DT_PACK_POPCNT_EN adds the fg_count foreground-pixel counter to dt_pack.
package dt_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_PIX   = 16384;
  localparam int WORD_BITS = 16;
  localparam int WORDS     = 1024;
  localparam int PIX_AW    = 14;
  localparam int WORD_AW   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/dt_pack_shreg.sv
// MSB-first serial-in/parallel-out shifter: the oldest bit ends up in word[15];
// the completed word is captured on the load strobe (16th bit of each word).
module dt_pack_shreg
  import dt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 bit_in,
  input  logic                 load,
  output logic [WORD_BITS-1:0] word
);

  // Only 15 bits need to be remembered; the 16th arrives with the load strobe.
  logic [WORD_BITS-2:0] shift_p0;
  logic [WORD_BITS-1:0] next_p0;

  assign next_p0 = {shift_p0, bit_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_p0 <= '0;
      word     <= '0;
    end else if (shift_en) begin
      shift_p0 <= next_p0[WORD_BITS-2:0];
      if (load) begin
        word <= next_p0;
      end
    end
  end

endmodule

// File: rtl/dt_pack.sv
// Scans the 128x128 byte result RAM, thresholds each pixel to one bit and writes
// MSB-first 16-bit words to the 1024x16 output RAM. Option: DT_PACK_POPCNT_EN (fg_count).
module dt_pack
  import dt_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 res_rd,
  output logic [PIX_AW-1:0]    res_addr,
  input  logic [7:0]           res_di,
  output logic                 sto_wr,
  output logic [WORD_AW-1:0]   sto_addr,
  output logic [WORD_BITS-1:0] sto_do
`ifdef DT_PACK_POPCNT_EN
  ,
  output logic [14:0]          fg_count
`endif
);

  function automatic logic thresh_bit(input logic [7:0] pix);
    return (pix >= THRESH);
  endfunction

  state_t state;
  logic   pix_bit;
  logic   word_end;
  logic   in_run;

  assign pix_bit  = thresh_bit(res_di);
  assign word_end = (res_addr[3:0] == 4'hF);
  assign in_run   = (state == RUN);

  dt_pack_shreg u_shreg (
    .clk      (clk),
    .reset    (reset),
    .shift_en (in_run),
    .bit_in   (pix_bit),
    .load     (in_run & word_end),
    .word     (sto_do)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      sto_wr   <= 1'b0;
      sto_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          sto_wr <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            res_rd   <= 1'b1;
            res_addr <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          // The counter wraps to 0 naturally after the last pixel.
          res_addr <= res_addr + 14'd1;
          sto_wr   <= word_end;
          if (word_end) begin
            sto_addr <= res_addr[PIX_AW-1:4];
          end
          if (res_addr == 14'(IMG_PIX - 1)) begin
            res_rd <= 1'b0;
            state  <= FIN;
          end
        end
        FIN: begin
          sto_wr <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DT_PACK_POPCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fg_count <= '0;
    end else if (state == IDLE && start) begin
      fg_count <= '0;
    end else if (in_run && pix_bit) begin
      fg_count <= fg_count + 15'd1;
    end
  end
`endif

endmodule
